icap_reg_reader: RTL and testbench
==================================

ICAP_REG_READER -- requirements
Module: icap_reg_reader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max READ-state cycles spent waiting for icap_busy low before abort (range 3..65535).
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request; sampled only in IDLE.
REQ-005 reg_addr  input  6  config register address; latched on accepted start.
REQ-006 busy  output  1  high from the cycle after accepted start through the done cycle.
REQ-007 done  output  1  one-cycle completion pulse.
REQ-008 error  output  1  timeout flag for the last transaction; valid with done, held until next accepted start.
REQ-009 rdata  output  16  captured register value; valid with done, held until next accepted start.
REQ-010 icap_ce  output  1  ICAP chip enable, active low.
REQ-011 icap_write  output  1  ICAP direction: 0 = write, 1 = read.
REQ-012 icap_i  output  16  ICAP write data.
REQ-013 icap_o  input  16  ICAP read data.
REQ-014 icap_busy  input  1  ICAP busy; low = icap_o valid during read.

Function
REQ-015 All outputs SHALL be registered; states IDLE, SYNC, TURN_R, READ, TURN_W, DESYNC, DONE.
REQ-016 IDLE: icap_ce=1, icap_write=1, icap_i=16'hFFFF, busy=0; start=1 -> latch reg_addr, clear error, go SYNC.
REQ-017 SYNC (7 cycles, icap_ce=0, icap_write=0) SHALL drive in order: FFFF, 5599, AA66, 2000, HDR, 2000, 2000.
REQ-018 HDR SHALL be type-1 read, one word: {3'b001, 2'b01, reg_addr, 5'b00001} (e.g. addr 0x08 -> 16'h2901).
REQ-019 TURN_R (1 cycle): icap_ce=1, icap_write=1, icap_i=16'h2000.
REQ-020 READ: icap_ce=0, icap_write=1; icap_busy ignored for first 2 cycles; from 3rd cycle on, first cycle with icap_busy=0 captures icap_o into rdata and exits to TURN_W.
REQ-021 READ cycle counter SHALL saturate, not wrap; reaching TIMEOUT cycles without capture -> rdata=0, error=1, go TURN_W.
REQ-022 TURN_W (1 cycle): icap_ce=1, icap_write=0, icap_i=16'h2000.
REQ-023 DESYNC (4 cycles, icap_ce=0, icap_write=0) SHALL drive: 30A1, 000D, 2000, 2000.
REQ-024 DONE (1 cycle): done=1, busy=1, ICAP pins at IDLE values; next cycle IDLE.
REQ-025 start outside IDLE SHALL be ignored; no queuing; reg_addr changes after acceptance SHALL have no effect.
REQ-026 icap_write SHALL change only in cycles where icap_ce=1 (turnaround rule).
REQ-027 With icap_busy=0 throughout, done SHALL rise 17 cycles after the accepting edge (7+1+3+1+4, then DONE).

Reset
REQ-028 rst=1 at any edge SHALL force IDLE, icap_ce=1, icap_write=1, icap_i=16'hFFFF, busy=0, done=0, error=0, rdata=0, counters=0.
REQ-029 Reset mid-transaction SHALL abort with no desync sequence and no done pulse; next start runs full sequence.
REQ-030 start asserted in same cycle as rst SHALL be ignored.

Verification
REQ-031 Reset then start, reg_addr=0x08, icap_busy=0, icap_o=16'h1234 -> icap_i sequence per REQ-017/023 with HDR 2901, done at cycle 17, rdata=1234, error=0.
REQ-032 icap_busy high for first 5 READ cycles, icap_o=16'hBEEF -> capture on READ cycle 6, done 3 cycles later than REQ-031, rdata=BEEF.
REQ-033 icap_busy stuck high, TIMEOUT=10 -> READ lasts 10 cycles, done pulse, error=1, rdata=0000, desync words still emitted.
REQ-034 start re-pulsed during SYNC and READ -> ignored; exactly one done; second start after DONE runs a new transaction with new reg_addr.
REQ-035 rst asserted during READ -> next cycle IDLE pin values, no done; subsequent start completes normally.
REQ-036 Assertion throughout all runs: icap_write never toggles while icap_ce=0; done only ever one cycle wide.

Source files
------------

// File: rtl/icap_reg_reader.sv
// icap_reg_reader: reads one configuration register through ICAP (sync, type-1 read header, busy-gated capture, desync)
//   clk, rst          : clock and synchronous active-high reset
//   start, reg_addr   : one-cycle request with register address, accepted only when idle
//   busy, done        : transaction in progress / one-cycle completion pulse
//   error, rdata      : timeout flag and captured word, valid with done and held until the next start
//   icap_ce, icap_write, icap_i : registered ICAP controls (ce active low, write 1 = read)
//   icap_o, icap_busy : ICAP read data and busy
module icap_reg_reader #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  reg_addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] rdata,
    output logic        icap_ce,
    output logic        icap_write,
    output logic [15:0] icap_i,
    input  logic [15:0] icap_o,
    input  logic        icap_busy
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SYNC   = 3'd1;
    localparam logic [2:0] TURN_R = 3'd2;
    localparam logic [2:0] READ   = 3'd3;
    localparam logic [2:0] TURN_W = 3'd4;
    localparam logic [2:0] DESYNC = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;
    localparam logic [15:0] LAST  = 16'(TIMEOUT - 1);

    logic [2:0]  state, ns;
    logic [15:0] cnt, ncnt;
    logic [5:0]  addr;
    logic        cap, tmo;
    logic        n_ce, n_wr;
    logic [15:0] n_i, sync_w, desync_w, hdr;

    always_comb begin
        ns = state;
        ncnt = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
        cap = 1'b0;
        tmo = 1'b0;
        case (state)
            IDLE: begin
                ncnt = '0;
                if (start) ns = SYNC;
            end
            SYNC: if (cnt == 16'd6) begin
                ns = TURN_R;
                ncnt = '0;
            end
            TURN_R: begin
                ns = READ;
                ncnt = '0;
            end
            // capture wins over timeout when busy drops in the final allowed cycle
            READ: if (cnt >= 16'd2 && !icap_busy) begin
                cap = 1'b1;
                ns = TURN_W;
                ncnt = '0;
            end else if (cnt == LAST) begin
                tmo = 1'b1;
                ns = TURN_W;
                ncnt = '0;
            end
            TURN_W: begin
                ns = DESYNC;
                ncnt = '0;
            end
            DESYNC: if (cnt == 16'd3) begin
                ns = DONE;
                ncnt = '0;
            end
            default: begin
                ns = IDLE;
                ncnt = '0;
            end
        endcase
    end

    // pins are decoded from the next state so they line up with the state they belong to
    assign hdr      = {3'b001, 2'b01, addr, 5'b00001};
    assign sync_w   = ncnt == 16'd0 ? 16'hFFFF : ncnt == 16'd1 ? 16'h5599 : ncnt == 16'd2 ? 16'hAA66 :
                      ncnt == 16'd4 ? hdr : 16'h2000;
    assign desync_w = ncnt == 16'd0 ? 16'h30A1 : ncnt == 16'd1 ? 16'h000D : 16'h2000;
    assign n_i      = ns == SYNC ? sync_w : ns == DESYNC ? desync_w :
                      (ns == IDLE || ns == DONE) ? 16'hFFFF : 16'h2000;
    assign n_ce     = !(ns == SYNC || ns == READ || ns == DESYNC);
    assign n_wr     = !(ns == SYNC || ns == TURN_W || ns == DESYNC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            rdata      <= '0;
            icap_ce    <= 1'b1;
            icap_write <= 1'b1;
            icap_i     <= 16'hFFFF;
        end else begin
            state      <= ns;
            cnt        <= ncnt;
            busy       <= ns != IDLE;
            done       <= ns == DONE;
            icap_ce    <= n_ce;
            icap_write <= n_wr;
            icap_i     <= n_i;
            if (state == IDLE && start) begin
                addr  <= reg_addr;
                error <= 1'b0;
            end
            if (cap) rdata <= icap_o;
            if (tmo) begin
                rdata <= '0;
                error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_icap_reg_reader.sv
// tb_icap_reg_reader: directed vector bench for icap_reg_reader
module tb_icap_reg_reader;
    localparam int TO = 10;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [5:0]  reg_addr = '0;
    logic        busy, done, error, icap_ce, icap_write;
    logic [15:0] rdata, icap_i;
    logic [15:0] icap_o = '0;
    logic        icap_busy = 1'b0;
    int nvec = 0, nbad = 0;

    icap_reg_reader #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .reg_addr(reg_addr),
        .busy(busy), .done(done), .error(error), .rdata(rdata),
        .icap_ce(icap_ce), .icap_write(icap_write), .icap_i(icap_i),
        .icap_o(icap_o), .icap_busy(icap_busy)
    );

    always #5 clk = ~clk;

    // bh = number of leading READ cycles with icap_busy high; dn = cycle of done, cycle 1 follows the accepting edge
    typedef struct {
        logic [5:0]  addr;
        logic [15:0] o;
        int          bh;
        logic [15:0] hdr;
        int          dn;
        logic [15:0] rd;
        logic        err;
        bit          rep;
    } vec_t;
    vec_t tv[6];

    function automatic logic [15:0] sw(int i, logic [15:0] hdr);
        case (i)
            0: return 16'hFFFF;
            1: return 16'h5599;
            2: return 16'hAA66;
            4: return hdr;
            default: return 16'h2000;
        endcase
    endfunction

    function automatic logic [15:0] dw(int i);
        case (i)
            0: return 16'h30A1;
            1: return 16'h000D;
            default: return 16'h2000;
        endcase
    endfunction

    // {word_checked, ce, write, word}
    function automatic logic [18:0] exp_pins(int k, int r, logic [15:0] hdr);
        if (k <= 7) return {3'b100, sw(k - 1, hdr)};
        if (k == 8) return {3'b111, 16'h2000};
        if (k <= 8 + r) return {3'b001, 16'h0000};
        if (k == 9 + r) return {3'b110, 16'h2000};
        if (k <= 13 + r) return {3'b100, dw(k - 10 - r)};
        return {3'b111, 16'hFFFF};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        int dc = 0, seqbad = 0, first = 0;
        int r = v.dn - 14;
        logic [18:0] e;
        logic [15:0] rd_at = 'x;
        logic er_at = 'x;
        reg_addr = v.addr;
        icap_o = v.o;
        icap_busy = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        reg_addr = ~v.addr;
        for (int k = 1; k <= v.dn + 3; k++) begin
            icap_busy = (k < 9 + v.bh);
            if (v.rep) start = (k == 3 || k == 10);
            @(negedge clk);
            e = exp_pins(k, r, v.hdr);
            if ({icap_ce, icap_write} !== e[17:16] || (e[18] && icap_i !== e[15:0]) ||
                busy !== (k <= v.dn) || done !== (k == v.dn)) begin
                seqbad++;
                if (first == 0) first = k;
            end
            if (done === 1'b1 && dc == 0) begin
                dc = k;
                rd_at = rdata;
                er_at = error;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (seqbad != 0) $display("vec %0d: first pin deviation in cycle %0d", idx, first);
        check($sformatf("v%0d pin_sequence_bad_cycles", idx), 64'(seqbad), 64'd0);
        check($sformatf("v%0d done_cycle", idx), 64'(dc), 64'(v.dn));
        check($sformatf("v%0d rdata", idx), 64'(rd_at), 64'(v.rd));
        check($sformatf("v%0d error", idx), 64'(er_at), 64'(v.err));
        check($sformatf("v%0d held_rdata_error", idx), {47'd0, rdata, error}, {47'd0, v.rd, v.err});
    endtask

    // turnaround and single-cycle done watch across the whole run
    logic pce = 1'b1, pw = 1'b1, pd = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (!pce && !icap_ce && icap_write !== pw) begin
                nbad++;
                $display("FAIL turnaround: icap_write %b, required %b while icap_ce low", icap_write, pw);
            end
            if (pd && done) begin
                nbad++;
                $display("FAIL done_width: done %b, required 0 after a done cycle", done);
            end
        end
        pce <= icap_ce;
        pw  <= icap_write;
        pd  <= done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        tv[0] = '{6'h08, 16'h1234, 0,  16'h2901, 17, 16'h1234, 1'b0, 1'b0};
        tv[1] = '{6'h0C, 16'hBEEF, 5,  16'h2981, 20, 16'hBEEF, 1'b0, 1'b0};
        tv[2] = '{6'h3F, 16'h5A5A, 99, 16'h2FE1, 24, 16'h0000, 1'b1, 1'b0};
        tv[3] = '{6'h00, 16'h0001, 9,  16'h2801, 24, 16'h0001, 1'b0, 1'b0};
        tv[4] = '{6'h16, 16'hCAFE, 1,  16'h2AC1, 17, 16'hCAFE, 1'b0, 1'b1};
        tv[5] = '{6'h07, 16'hFFFF, 2,  16'h28E1, 17, 16'hFFFF, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_state", {27'd0, icap_ce, icap_write, icap_i, busy, done, error, rdata},
              {27'd0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000});

        start = 1'b1;
        reg_addr = 6'h08;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("start_with_rst_ignored", {62'd0, busy, icap_ce}, {62'd0, 1'b0, 1'b1});
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run(tv[i], i);

        start = 1'b1;
        reg_addr = 6'h08;
        icap_busy = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_read", {27'd0, icap_ce, icap_write, icap_i, busy, done, error, rdata},
              {27'd0, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000});
        nd = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) nd++;
        end
        check("no_activity_after_rst", 64'(nd), 64'd0);
        @(posedge clk); #1;
        run(tv[0], 6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
